// File: rtl/xcvr_tx_pump_pkg.sv
// Shared definitions for the transceiver tx data pump.
//   pump_state_t      : pump FSM state encoding (IDLE=0, WAIT=1, RUN=2)
//   IDLE_WORD_DEFAULT : word sent when no FIFO data is available
//   UNDERRUN_CNT_W    : width of the saturating underrun counter
package xcvr_tx_pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } pump_state_t;

  localparam logic [63:0] IDLE_WORD_DEFAULT = 64'h0707_0707_0707_0707;
  localparam int unsigned UNDERRUN_CNT_W    = 16;

endpackage

// File: rtl/xcvr_tx_pump_sat_cnt.sv
// Saturating up-counter used for the underrun count.
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset, clears the count
//   inc     : increment request, ignored once the count is all-ones
//   count   : current count
module xcvr_tx_pump_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/xcvr_tx_data_pump.sv
// Transceiver tx data pump: streams words from a non-show-ahead tx FIFO onto
// the transceiver parallel interface, filling gaps with IDLE_WORD.
// Optional feature macro: XCVR_TX_PUMP_UNDERRUN_CNT_EN builds the saturating
// underrun counter; without it underrun_count is tied to zero.
// Ports:
//   clk            : single clock, shared with the FIFO read side
//   reset_n        : synchronous active-low reset
//   enable         : streaming request
//   fifo_q         : FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdempty   : FIFO empty flag
//   fifo_rdreq     : FIFO read request (combinational)
//   tx_data        : transceiver parallel data (registered)
//   tx_is_idle     : high when tx_data carries IDLE_WORD
//   underrun       : sticky, set on first RUN cycle with an empty FIFO
//   underrun_count : saturating count of underrun cycles
//   state          : current FSM state encoding
module xcvr_tx_data_pump
  import xcvr_tx_pump_pkg::*;
#(
  parameter int unsigned START_DELAY = 4,
  parameter logic [63:0] IDLE_WORD   = IDLE_WORD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [63:0]               fifo_q,
  input  logic                      fifo_rdempty,
  output logic                      fifo_rdreq,
  output logic [63:0]               tx_data,
  output logic                      tx_is_idle,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count,
  output logic [1:0]                state
);

  // Delay counter runs 0..START_DELAY-1; the last low cycle moves to RUN.
  localparam int unsigned      DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);

  pump_state_t      state_q;
  pump_state_t      state_d;
  logic [DLY_W-1:0] dly_cnt;
  logic             dly_done;
  logic             rd_valid;
  logic             underrun_inc;

  assign dly_done     = ~fifo_rdempty && (dly_cnt == DLY_LAST);
  assign underrun_inc = (state_q == ST_RUN) && fifo_rdempty;
  assign state        = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fifo_rdreq = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT;
        ST_WAIT: if (dly_done) state_d = ST_RUN;
        ST_RUN:  fifo_rdreq = ~fifo_rdempty;
        default: state_d = ST_IDLE;
      endcase
    end
    // Reset is combinationally folded in so no read escapes while reset_n is low.
    if (!reset_n) begin
      fifo_rdreq = 1'b0;
    end
  end

  // Counting only while in WAIT with the FIFO non-empty; any other condition
  // (empty pulse, leaving WAIT, sitting in IDLE) restarts it from zero, which
  // also guarantees a fresh count on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dly_cnt <= '0;
    end else if ((state_q == ST_WAIT) && enable && ~fifo_rdempty && !dly_done) begin
      dly_cnt <= dly_cnt + DLY_W'(1);
    end else begin
      dly_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      tx_data    <= IDLE_WORD;
      tx_is_idle <= 1'b1;
      underrun   <= 1'b0;
    end else begin
      rd_valid <= fifo_rdreq;
      if (rd_valid) begin
        tx_data    <= fifo_q;
        tx_is_idle <= 1'b0;
      end else begin
        tx_data    <= IDLE_WORD;
        tx_is_idle <= 1'b1;
      end
      if (underrun_inc) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef XCVR_TX_PUMP_UNDERRUN_CNT_EN
  xcvr_tx_pump_sat_cnt #(
    .WIDTH (UNDERRUN_CNT_W)
  ) u_underrun_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (underrun_inc),
    .count   (underrun_count)
  );
`else
  assign underrun_count = '0;
`endif

endmodule

// File: doc/xcvr_tx_data_pump.md
XCVR_TX_DATA_PUMP -- requirements
Module: xcvr_tx_data_pump

Interface
REQ-001 SHALL have parameter START_DELAY, default 4: consecutive cycles fifo_rdempty must be low in WAIT before streaming begins.
REQ-002 SHALL have parameter IDLE_WORD, default 64'h0707_0707_0707_0707: word driven when no FIFO data is available.
REQ-003 SHALL have port clk, input, 1: single clock, shared with the tx FIFO read side.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: streaming request from the control/status block.
REQ-006 SHALL have port fifo_q, input, 64: tx FIFO read data (dataout).
REQ-007 SHALL have port fifo_rdempty, input, 1: tx FIFO empty flag.
REQ-008 SHALL have port fifo_rdreq, output, 1: tx FIFO read request.
REQ-009 SHALL have port tx_data, output, 64: transceiver parallel data.
REQ-010 SHALL have port tx_is_idle, output, 1: high when tx_data carries IDLE_WORD.
REQ-011 SHALL have port underrun, output, 1: sticky flag, set on the first underrun.
REQ-012 SHALL have port underrun_count, output, 16: saturating underrun count.
REQ-013 SHALL have port state, output, 2: current state encoding.

Function
REQ-014 SHALL implement states IDLE=0, WAIT=1, RUN=2.
- IDLE->WAIT when enable=1.
- WAIT->RUN when fifo_rdempty has been low for START_DELAY consecutive cycles.
- Any state->IDLE when enable=0.
REQ-015 SHALL reset the WAIT delay counter whenever fifo_rdempty=1 while in WAIT, and on every entry to WAIT.
REQ-016 SHALL drive fifo_rdreq combinationally as (state==RUN) & ~fifo_rdempty & enable; this never reads an empty FIFO.
REQ-017 SHALL treat the FIFO as non-show-ahead: fifo_q is valid one cycle after fifo_rdreq, tracked by a registered rd_valid bit.
REQ-018 SHALL register tx_data, giving a latency of exactly 2 cycles from fifo_rdreq to tx_data.
- If rd_valid=1: tx_data<=fifo_q and tx_is_idle<=0.
- Otherwise: tx_data<=IDLE_WORD and tx_is_idle<=1.
REQ-019 SHALL count an underrun on every cycle that is in RUN with fifo_rdempty=1: underrun_count increments, saturating at 16'hFFFF, and underrun is set.
REQ-020 SHALL NOT count underruns in IDLE or WAIT.
REQ-021 SHALL still output a word that is in flight (rd_valid=1) when enable drops, then output IDLE_WORD.
REQ-022 SHALL clear underrun and underrun_count only by reset.
REQ-023 SHALL treat an enable rising edge and a reset in the same cycle as reset-only (reset wins).

Reset
REQ-024 SHALL, while reset_n=0 at a clk edge, set:
- state=IDLE;
- rd_valid=0, delay counter=0;
- tx_data=IDLE_WORD, tx_is_idle=1;
- underrun=0, underrun_count=0.
REQ-025 SHALL hold fifo_rdreq=0 during reset, including when reset is asserted mid-stream; the word in flight is discarded.

Configuration
REQ-026 SHALL use macro XCVR_TX_PUMP_UNDERRUN_CNT_EN.
- Defined: the underrun_count counter is implemented as above.
- Undefined: underrun_count is tied to 0 and no counter logic is built; the underrun sticky flag is always present.

Structure
REQ-027 SHALL place in package xcvr_tx_pump_pkg:
- the state typedef (2-bit enum);
- the default IDLE_WORD constant;
- the underrun counter width constant (16).
REQ-028 SHALL implement the saturating counter as sub-module xcvr_tx_pump_sat_cnt, instantiated only when XCVR_TX_PUMP_UNDERRUN_CNT_EN is defined.

Verification
REQ-029 Reset release with enable=0 -> tx_data=64'h0707070707070707, tx_is_idle=1, fifo_rdreq=0, state=0 indefinitely.
REQ-030 enable=1, rdempty low from cycle 0 -> state=RUN after 4 cycles of WAIT; words 64'h1,64'h2,64'h3 appear on tx_data 2 cycles after their respective rdreq, with tx_is_idle=0.
REQ-031 In WAIT, rdempty pulses high at delay count 3 -> delay counter restarts, and RUN is entered only after 4 further low cycles.
REQ-032 In RUN, rdempty high for 3 cycles -> 3 idle words out, underrun=1, underrun_count=3, no rdreq during the empty cycles; underrun_count=0 when the macro is undefined.
REQ-033 Force underrun_count to 16'hFFFE, then 5 underrun cycles -> count holds at 16'hFFFF.
REQ-034 enable drops one cycle after rdreq -> the pending word still appears on tx_data, then IDLE_WORD follows; reset_n=0 mid-stream -> all outputs at reset values on the next edge.
